// File: rtl/quad_phase_pkg.sv
`default_nettype none
// ============================================================================
// Module : quad_phase_pkg
// Brief  : Shared phase/mode types, output masks and one-hot phase decode.
// Rev    : 1.0
// ============================================================================
package quad_phase_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        MODE_IQ50 = 1'b0,
        MODE_PH25 = 1'b1
    } mode_t;

    // Bit n of each mask is the output level while the phase state equals n.
    localparam logic [3:0] PHASE_I_MASK = 4'b0011;
    localparam logic [3:0] PHASE_Q_MASK = 4'b0110;

    function automatic logic [3:0] phase_onehot(input phase_t p);
        phase_onehot = 4'b0001 << p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_phase_divider_if.sv
`default_nettype none
// ============================================================================
// Module : quad_phase_divider_if
// Brief  : Control/status bundle of the quadrature divider. With
//          QUAD_PHASE_REVERSE_EN defined it also carries reverse_in.
// Rev    : 1.0
// ============================================================================
interface quad_phase_divider_if #(
    parameter int unsigned DIV_W = 8
);
    logic             enable;
    logic [DIV_W-1:0] div_in;
    logic             mode_in;
    logic             load;
`ifdef QUAD_PHASE_REVERSE_EN
    logic             reverse_in;
`endif
    logic             cfg_pending;
    logic             out_i;
    logic             out_q;
    logic [3:0]       phase_out;
    logic             wrap;

`ifdef QUAD_PHASE_REVERSE_EN
    modport master (
        output enable, div_in, mode_in, load, reverse_in,
        input  cfg_pending, out_i, out_q, phase_out, wrap
    );
    modport slave (
        input  enable, div_in, mode_in, load, reverse_in,
        output cfg_pending, out_i, out_q, phase_out, wrap
    );
`else
    modport master (
        output enable, div_in, mode_in, load,
        input  cfg_pending, out_i, out_q, phase_out, wrap
    );
    modport slave (
        input  enable, div_in, mode_in, load,
        output cfg_pending, out_i, out_q, phase_out, wrap
    );
`endif
endinterface
`default_nettype wire

// File: rtl/quad_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module : quad_tick_prescaler
// Brief  : Enable-gated counter producing one tick every div_active+1 cycles.
// Rev    : 1.0
// ============================================================================
module quad_tick_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_active,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // >= rather than == so a divisor lowered below the held count still ticks.
    always_comb begin
        tick  = enable && (cnt_q >= div_active);
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/quad_phase_divider.sv
`default_nettype none
// ============================================================================
// Module : quad_phase_divider
// Brief  : Synchronous quadrature generator: I/Q 50% or four 25% strobes,
//          runtime divisor/mode applied at phase wrap. Optional macro
//          QUAD_PHASE_REVERSE_EN adds reverse rotation.
// Rev    : 1.0
// ============================================================================
module quad_phase_divider
    import quad_phase_pkg::*;
#(
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned RST_DIV  = 0,
    parameter int unsigned RST_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    quad_phase_divider_if.slave  bus
);

    localparam logic [DIV_W-1:0] RST_DIV_V  = DIV_W'(RST_DIV);
    localparam mode_t            RST_MODE_E = (RST_MODE != 0) ? MODE_PH25 : MODE_IQ50;

    logic             tick;
    logic             reverse;
    logic             wrap_edge;
    logic             apply_cfg;

    phase_t           phase_q,       phase_d;
    logic [DIV_W-1:0] div_active_q,  div_active_d;
    logic [DIV_W-1:0] div_shadow_q,  div_shadow_d;
    mode_t            mode_active_q, mode_active_d;
    mode_t            mode_shadow_q, mode_shadow_d;
    logic             cfg_pending_q, cfg_pending_d;
    logic             wrap_q,        wrap_d;
    logic             out_i_q,       out_i_d;
    logic             out_q_q,       out_q_d;
    logic [3:0]       phase_out_q,   phase_out_d;

    quad_tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .enable     (bus.enable),
        .div_active (div_active_q),
        .tick       (tick)
    );

    // A frozen divider takes new config at once; a running one waits for wrap.
    assign wrap_edge = tick && (phase_q == (reverse ? 2'd1 : 2'd3));
    assign apply_cfg = cfg_pending_q && (!bus.enable || wrap_edge);

`ifdef QUAD_PHASE_REVERSE_EN
    logic reverse_active_q, reverse_active_d;
    logic reverse_shadow_q, reverse_shadow_d;

    assign reverse = reverse_active_q;

    always_comb begin
        reverse_active_d = reverse_active_q;
        reverse_shadow_d = reverse_shadow_q;
        if (apply_cfg) begin
            reverse_active_d = reverse_shadow_q;
        end
        if (bus.load) begin
            reverse_shadow_d = bus.reverse_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reverse_active_q <= 1'b0;
            reverse_shadow_q <= 1'b0;
        end else begin
            reverse_active_q <= reverse_active_d;
            reverse_shadow_q <= reverse_shadow_d;
        end
    end
`else
    assign reverse = 1'b0;
`endif

    always_comb begin
        phase_d       = phase_q;
        div_active_d  = div_active_q;
        div_shadow_d  = div_shadow_q;
        mode_active_d = mode_active_q;
        mode_shadow_d = mode_shadow_q;
        cfg_pending_d = cfg_pending_q;
        wrap_d        = wrap_edge;

        if (tick) begin
            phase_d = reverse ? (phase_q - 2'd1) : (phase_q + 2'd1);
        end

        // Apply before capture so a load on the wrap edge stays pending.
        if (apply_cfg) begin
            div_active_d  = div_shadow_q;
            mode_active_d = mode_shadow_q;
            cfg_pending_d = 1'b0;
        end
        if (bus.load) begin
            div_shadow_d  = bus.div_in;
            mode_shadow_d = mode_t'(bus.mode_in);
            cfg_pending_d = 1'b1;
        end

        phase_out_d = phase_onehot(phase_d);
        if (mode_active_d == MODE_IQ50) begin
            out_i_d = PHASE_I_MASK[phase_d];
            out_q_d = PHASE_Q_MASK[phase_d];
        end else begin
            out_i_d = phase_out_d[0];
            out_q_d = phase_out_d[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= 2'd0;
            div_active_q  <= RST_DIV_V;
            div_shadow_q  <= RST_DIV_V;
            mode_active_q <= RST_MODE_E;
            mode_shadow_q <= RST_MODE_E;
            cfg_pending_q <= 1'b0;
            wrap_q        <= 1'b0;
            out_i_q       <= 1'b1;
            out_q_q       <= 1'b0;
            phase_out_q   <= 4'b0001;
        end else begin
            phase_q       <= phase_d;
            div_active_q  <= div_active_d;
            div_shadow_q  <= div_shadow_d;
            mode_active_q <= mode_active_d;
            mode_shadow_q <= mode_shadow_d;
            cfg_pending_q <= cfg_pending_d;
            wrap_q        <= wrap_d;
            out_i_q       <= out_i_d;
            out_q_q       <= out_q_d;
            phase_out_q   <= phase_out_d;
        end
    end

    assign bus.cfg_pending = cfg_pending_q;
    assign bus.out_i       = out_i_q;
    assign bus.out_q       = out_q_q;
    assign bus.phase_out   = phase_out_q;
    assign bus.wrap        = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_phase_divider.sv
`default_nettype none
// ============================================================================
// Module : tb_quad_phase_divider
// Brief  : Directed and random scenarios against a phase-timeline model.
// Rev    : 1.0
// ============================================================================
module tb_quad_phase_divider;

    localparam int DIV_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quad_phase_divider_if #(.DIV_W(DIV_W)) bus ();

    quad_phase_divider #(
        .DIV_W    (DIV_W),
        .RST_DIV  (0),
        .RST_MODE (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a phase lasts div+1 enabled cycles; m_spent counts those used so far.
    int m_phase, m_spent, m_div, m_mode, m_sh_div, m_sh_mode;
    bit m_pending, m_wrap;

    logic [7:0] dut_vec;
    assign dut_vec = {bus.out_i, bus.out_q, bus.phase_out, bus.wrap, bus.cfg_pending};

    function automatic logic [7:0] expected_vec();
        bit ei, eq;
        logic [3:0] oh;
        oh = 4'(1 << m_phase);
        if (m_mode == 0) begin
            ei = (m_phase < 2);
            eq = (m_phase == 1) || (m_phase == 2);
        end else begin
            ei = (m_phase == 0);
            eq = (m_phase == 1);
        end
        return {ei, eq, oh, m_wrap, m_pending};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_spent = 0; m_div = 0; m_mode = 0;
        m_sh_div = 0; m_sh_mode = 0; m_pending = 0; m_wrap = 0;
    endtask

    task automatic model_clock();
        bit wrapped;
        wrapped = 0;
        if (bus.enable) begin
            m_spent++;
            if (m_spent >= m_div + 1) begin
                m_phase = (m_phase + 1) % 4;
                m_spent = 0;
                wrapped = (m_phase == 0);
            end
        end
        if (m_pending && (!bus.enable || wrapped)) begin
            m_div = m_sh_div; m_mode = m_sh_mode; m_pending = 0;
        end
        if (bus.load) begin
            m_sh_div = int'(bus.div_in); m_sh_mode = int'(bus.mode_in); m_pending = 1;
        end
        m_wrap = wrapped;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_clock();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable = 1'b0; bus.load = 1'b0; bus.div_in = '0; bus.mode_in = 1'b0;
`ifdef QUAD_PHASE_REVERSE_EN
        bus.reverse_in = 1'b0;
`endif
        #1;
        total++;
        if (dut_vec !== 8'b10_0001_00) begin
            bad++; $display("FAIL reset_async t=%0t got=%b exp=%b", $time, dut_vec, 8'b10_0001_00);
        end
        step(); step();
        total++;
        if (dut_vec !== 8'b10_0001_00) begin
            bad++; $display("FAIL reset_held got=%b exp=%b", dut_vec, 8'b10_0001_00);
        end
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_div0_iq();
        bus.enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            total++;
            if (dut_vec !== expected_vec()) begin
                bad++; $display("FAIL div0_iq cyc=%0d got=%b exp=%b", cyc, dut_vec, expected_vec());
            end
        end
    endtask

    task automatic test_load_mode1();
        int guard = 0;
        while (m_phase != 1 && guard < 50) begin step(); guard++; end
        if (guard >= 50) begin bad++; total++; $display("FAIL mode1_wait got=timeout exp=phase1"); end
        bus.load = 1'b1; bus.div_in = 8'd2; bus.mode_in = 1'b1;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            total++;
            if (dut_vec !== expected_vec()) begin
                bad++; $display("FAIL load_mode1 cyc=%0d got=%b exp=%b", cyc, dut_vec, expected_vec());
            end
            step();
        end
    endtask

    task automatic test_div_reduce();
        int guard = 0;
        bus.load = 1'b1; bus.div_in = 8'd9; bus.mode_in = 1'b0;
        step();
        bus.load = 1'b0;
        while ((m_pending || m_phase != 1 || m_spent != 7) && guard < 200) begin step(); guard++; end
        if (guard >= 200) begin bad++; total++; $display("FAIL reduce_wait got=timeout exp=cnt7"); end
        bus.load = 1'b1; bus.div_in = 8'd3;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 60; k++) begin
            total++;
            if (dut_vec !== expected_vec()) begin
                bad++; $display("FAIL div_reduce cyc=%0d got=%b exp=%b", cyc, dut_vec, expected_vec());
            end
            step();
        end
    endtask

    task automatic test_enable_hold();
        int guard = 0;
        while ((m_phase != 2 || m_spent != 1) && guard < 50) begin step(); guard++; end
        if (guard >= 50) begin bad++; total++; $display("FAIL hold_wait got=timeout exp=phase2"); end
        bus.enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (dut_vec !== expected_vec()) begin
                bad++; $display("FAIL enable_hold cyc=%0d got=%b exp=%b", cyc, dut_vec, expected_vec());
            end
        end
        bus.enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (dut_vec !== expected_vec()) begin
                bad++; $display("FAIL enable_resume cyc=%0d got=%b exp=%b", cyc, dut_vec, expected_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        bus.load = 1'b1; bus.div_in = 8'd5;
        step();
        bus.div_in = 8'd1;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 30; k++) begin
            total++;
            if (dut_vec !== expected_vec()) begin
                bad++; $display("FAIL two_loads cyc=%0d got=%b exp=%b", cyc, dut_vec, expected_vec());
            end
            step();
        end
        // Park the load on the very edge that wraps 3 -> 0.
        while (!(m_phase == 3 && m_spent + 1 >= m_div + 1) && guard < 50) begin step(); guard++; end
        if (guard >= 50) begin bad++; total++; $display("FAIL wrap_wait got=timeout exp=wrap_edge"); end
        bus.load = 1'b1; bus.div_in = 8'd2; bus.mode_in = 1'b0;
        step();
        bus.load = 1'b0;
        total++;
        if ({bus.wrap, bus.cfg_pending} !== 2'b11) begin
            bad++; $display("FAIL load_on_wrap got=%b exp=%b", {bus.wrap, bus.cfg_pending}, 2'b11);
        end
        for (int k = 0; k < 40; k++) begin
            step();
            total++;
            if (dut_vec !== expected_vec()) begin
                bad++; $display("FAIL after_wrap_load cyc=%0d got=%b exp=%b", cyc, dut_vec, expected_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        bus.load = 1'b1; bus.div_in = 8'd4; bus.mode_in = 1'b1;
        step();
        bus.load = 1'b0;
        while (m_phase != 3 && guard < 50) begin step(); guard++; end
        if (guard >= 50) begin bad++; total++; $display("FAIL rst_wait got=timeout exp=phase3"); end
        bus.load = 1'b1; bus.div_in = 8'd7;
        step();
        bus.load = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (dut_vec !== 8'b10_0001_00) begin
            bad++; $display("FAIL reset_mid got=%b exp=%b", dut_vec, 8'b10_0001_00);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (dut_vec !== expected_vec()) begin
                bad++; $display("FAIL after_reset cyc=%0d got=%b exp=%b", cyc, dut_vec, expected_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bus.enable  = ($urandom_range(0, 7) != 0);
            bus.load    = ($urandom_range(0, 15) == 0);
            bus.div_in  = DIV_W'($urandom_range(0, 5));
            bus.mode_in = 1'($urandom_range(0, 1));
            step();
            total++;
            if (dut_vec !== expected_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec, expected_vec());
            end
        end
        bus.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_div0_iq();
        test_load_mode1();
        test_div_reduce();
        test_enable_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
